// File: rtl/restoring_divider_8bit.sv
// restoring_divider_8bit
//   Sequential unsigned restoring divider (DIV/MOD unit of the ALU).
//   One trial subtraction per clock; a borrowing subtraction is restored by
//   keeping the shifted partial remainder instead of the difference.
//   Latency is WIDTH+1 cycles from an accepted start to done.
//
// Ports
//   clk          in   1      system clock, rising-edge active
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      request, sampled only in IDLE
//   dividend     in   WIDTH  unsigned dividend, latched on accept
//   divisor      in   WIDTH  unsigned divisor, latched on accept
//   busy         out  1      high in CALC and DONE
//   done         out  1      one-cycle completion pulse
//   quotient     out  WIDTH  unsigned quotient, held until next accept
//   remainder    out  WIDTH  unsigned remainder, held until next accept
//   div_by_zero  out  1      set with done when divisor was zero
module restoring_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // The partial remainder's top bit is always zero after an update (a
  // non-borrowing trial leaves T < divisor), so only WIDTH bits are stored.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             last_iter_s;
  logic             divisor_zero_s;

  assign shifted_s      = {1'b0, p_q[WIDTH-1:0], q_q[WIDTH-1]} >> 0;
  assign trial_s        = shifted_s - {1'b0, divisor_q};
  assign last_iter_s    = (count_q == CW'(WIDTH - 1));
  assign divisor_zero_s = (divisor == {WIDTH{1'b0}});

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      p_q         <= {WIDTH{1'b0}};
      q_q         <= {WIDTH{1'b0}};
      divisor_q   <= {WIDTH{1'b0}};
      count_q     <= {CW{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: IDLE -> CALC (or DONE on zero divisor) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = divisor_zero_s ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_iter_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    p_d         = p_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          divisor_d = divisor;
          p_d       = {WIDTH{1'b0}};
          q_d       = dividend;
          count_d   = {CW{1'b0}};
          if (divisor_zero_s) begin
            // Zero divisor short-circuits straight to DONE.
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            dbz_d = dbz_q;
          end
        end else begin
          count_d = count_q;
        end
      end
      S_CALC: begin
        if (!trial_s[WIDTH]) begin
          p_d = trial_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          // Borrow: restore by keeping the shifted remainder.
          p_d = shifted_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (last_iter_s) begin
          quotient_d  = q_d;
          remainder_d = p_d;
          dbz_d       = 1'b0;
        end else begin
          dbz_d = dbz_q;
        end
      end
      S_DONE: begin
        count_d = count_q;
      end
      default: begin
        count_d = {CW{1'b0}};
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// tb_restoring_divider_8bit
//   Directed, table-driven bench for restoring_divider_8bit (WIDTH = 8)
//   plus hand-written sequences for busy-time starts and mid-CALC reset.
module tb_restoring_divider_8bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
    logic       hammer;  // hold start high while busy
  } vec_t;

  vec_t vecs [8];

  restoring_divider_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_vec(input vec_t v);
    int cyc;
    start    = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    @(posedge clk);  // E0
    @(negedge clk);
    cyc = 1;
    // Scramble operands; the DUT must have latched them.
    dividend = 8'hA5;
    divisor  = 8'h00;
    if (v.hammer) begin
      start    = 1'b1;
      dividend = 8'd1;
      divisor  = 8'd1;
    end else begin
      start = 1'b0;
    end
    chk("busy_after_accept", busy, 1'b1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, v.lat);
    chk("quotient", quotient, v.q);
    chk("remainder", remainder, v.r);
    chk("div_by_zero", div_by_zero, v.dbz);
    chk("busy_in_done", busy, 1'b1);
    @(negedge clk);
    chk("done_pulse_width", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("quotient_held", quotient, v.q);
    chk("remainder_held", remainder, v.r);
  endtask

  initial begin
    int seen_done;
    vecs[0] = '{a: 8'd148, b: 8'd133, q: 8'd1,   r: 8'd15, dbz: 1'b0, lat: 9, hammer: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd204, q: 8'd1,   r: 8'd51, dbz: 1'b0, lat: 9, hammer: 1'b1};
    vecs[2] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dbz: 1'b0, lat: 9, hammer: 1'b0};
    vecs[3] = '{a: 8'd7,   b: 8'd9,   q: 8'd0,   r: 8'd7,  dbz: 1'b0, lat: 9, hammer: 1'b0};
    vecs[4] = '{a: 8'd5,   b: 8'd0,   q: 8'd255, r: 8'd5,  dbz: 1'b1, lat: 1, hammer: 1'b0};
    vecs[5] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dbz: 1'b0, lat: 9, hammer: 1'b0};
    vecs[6] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0, lat: 9, hammer: 1'b0};
    vecs[7] = '{a: 8'd100, b: 8'd3,   q: 8'd33,  r: 8'd1,  dbz: 1'b0, lat: 9, hammer: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, 8'd0);
    chk("rst_remainder", remainder, 8'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back table run (vector 7 is reserved for after the reset test).
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].hammer) begin
        // A start held during busy must not have been queued.
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (done || busy) seen_done = 1;
        end
        chk("no_queued_start", seen_done, 0);
      end
    end

    // Reset during CALC of 100/3: abort, outputs cleared, no done.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd3;
    @(posedge clk);  // E0
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quotient", quotient, 8'd0);
    chk("abort_remainder", remainder, 8'd0);
    chk("abort_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);

    run_vec(vecs[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
